// File: rtl/tlb_pkg.sv
// Shared types and helpers for the 32-entry LoongArch-32 TLB: entry layout,
// page-size constants, INVTLB opcodes and the translation result record.
package tlb_pkg;

    localparam int unsigned TLBNUM = 32;
    localparam int unsigned IDXW   = $clog2(TLBNUM);

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd21;

    typedef enum logic [4:0] {
        INV_ALL     = 5'd0,
        INV_ALL_ALT = 5'd1,
        INV_GLOBAL  = 5'd2,
        INV_PRIVATE = 5'd3,
        INV_ASID    = 5'd4,
        INV_ASID_VA = 5'd5,
        INV_VA      = 5'd6
    } invtlb_op_e;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
    } tlb_key_t;

    typedef struct packed {
        tlb_key_t        key;
        tlb_page_t [1:0] page;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0]     pa;
        logic            found;
        logic [IDXW-1:0] idx;
        logic            v;
        logic            d;
        logic [1:0]      mat;
        logic [1:0]      plv;
    } trans_res_t;

    function automatic logic vppn_hit(input logic [18:0] ent_vppn, input logic [5:0] ps,
                                      input logic [18:0] vppn);
        case (ps)
            PS_4K:   return ent_vppn == vppn;
            PS_4M:   return ent_vppn[18:9] == vppn[18:9];
            default: return ent_vppn == vppn;
        endcase
    endfunction

    // Priority: direct > TLB mapping > DMW0 > DMW1 > identity.
    function automatic trans_res_t translate(
        input logic            direct,
        input logic            map_en,
        input logic            dmw0_en,
        input logic            dmw1_en,
        input logic [2:0]      pseg0,
        input logic [2:0]      pseg1,
        input logic [31:0]     va,
        input logic            hit,
        input logic [IDXW-1:0] idx,
        input logic [5:0]      ps,
        input tlb_page_t [1:0] pages
    );
        trans_res_t r;
        tlb_page_t  pg;
        logic       huge;
        r      = '0;
        r.pa   = va;
        r.mat  = 2'b01;
        huge   = (ps == PS_4M);
        pg     = huge ? pages[va[21]] : pages[va[12]];
        if (!direct) begin
            if (map_en) begin
                r.mat = '0;
                if (hit) begin
                    r.found = 1'b1;
                    r.idx   = idx;
                    r.v     = pg.v;
                    r.d     = pg.d;
                    r.mat   = pg.mat;
                    r.plv   = pg.plv;
                    r.pa    = huge ? {pg.ppn[19:9], va[20:0]} : {pg.ppn, va[11:0]};
                end
            end else if (dmw0_en) begin
                r.pa = {pseg0, va[28:0]};
            end else if (dmw1_en) begin
                r.pa = {pseg1, va[28:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tlb_trans_addr_match.sv
// Combinational associative match of one {vppn, asid} query against all entry keys.
module tlb_match
    import tlb_pkg::*;
(
    input  tlb_key_t [TLBNUM-1:0] entries_i,
    input  logic [18:0]           vppn_i,
    input  logic [9:0]            asid_i,
    output logic                  found_o,
    output logic [IDXW-1:0]       index_o
);

    logic [TLBNUM-1:0] match;

    // Entries are kept unique, so OR-ing indices of the hits yields the single hit index.
    always_comb begin
        match   = '0;
        index_o = '0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            match[i] = entries_i[i].e
                    && (entries_i[i].g || (entries_i[i].asid == asid_i))
                    && vppn_hit(entries_i[i].vppn, entries_i[i].ps, vppn_i);
            if (match[i]) index_o = index_o | IDXW'(i);
        end
        found_o = |match;
    end

endmodule

// File: rtl/tlb_trans_addr.sv
// 32-entry fully associative TLB with registered inst/data translation,
// TLBSRCH/TLBRD results, and TLBWR/TLBFILL/INVTLB state updates.
module tlb_trans_addr
    import tlb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  asid,
    input  logic        inst_addr_trans_en,
    input  logic        data_addr_trans_en,
    input  logic        inst_fetch,
    input  logic        data_fetch,
    input  logic [31:0] inst_vaddr,
    input  logic [31:0] data_vaddr,
    input  logic        inst_dmw0_en,
    input  logic        inst_dmw1_en,
    input  logic        data_dmw0_en,
    input  logic        data_dmw1_en,
    input  logic        cacop_op_mode_di,
    output logic [7:0]  inst_index,
    output logic [19:0] inst_tag,
    output logic [3:0]  inst_offset,
    output logic [7:0]  data_index,
    output logic [19:0] data_tag,
    output logic [3:0]  data_offset,
    output logic        inst_tlb_found,
    output logic        data_tlb_found,
    output logic [4:0]  data_tlb_index,
    output logic        inst_tlb_v,
    output logic        inst_tlb_d,
    output logic [1:0]  inst_tlb_mat,
    output logic [1:0]  inst_tlb_plv,
    output logic        data_tlb_v,
    output logic        data_tlb_d,
    output logic [1:0]  data_tlb_mat,
    output logic [1:0]  data_tlb_plv,
    input  logic        tlbsrch_en,
    input  logic [31:0] tlbsrch_ehi,
    output logic        search_tlb_found,
    output logic [4:0]  search_tlb_index,
    input  logic        tlbfill_en,
    input  logic        tlbwr_en,
    input  logic [4:0]  rand_index,
    input  logic [31:0] tlbehi_in,
    input  logic [31:0] tlbelo0_in,
    input  logic [31:0] tlbelo1_in,
    input  logic [31:0] tlbidx_in,
    input  logic [5:0]  ecode_in,
    output logic [31:0] tlbehi_out,
    output logic [31:0] tlbelo0_out,
    output logic [31:0] tlbelo1_out,
    output logic [31:0] tlbidx_out,
    output logic [9:0]  asid_out,
    input  logic        invtlb_en,
    input  logic [9:0]  invtlb_asid,
    input  logic [18:0] invtlb_vpn,
    input  logic [4:0]  invtlb_op,
    input  logic [31:0] csr_dmw0,
    input  logic [31:0] csr_dmw1,
    input  logic        csr_da,
    input  logic        csr_pg
);

    tlb_entry_t [TLBNUM-1:0] tlb_q, tlb_d;
    tlb_key_t   [TLBNUM-1:0] keys;
    tlb_entry_t              rd_q;
    tlb_entry_t              new_ent;
    trans_res_t              inst_res_d, inst_res_q, data_res_d, data_res_q;
    logic                    srch_found_q;
    logic [IDXW-1:0]         srch_idx_q;
    logic                    i_hit, d_hit, s_hit, wr_en;
    logic [IDXW-1:0]         i_idx, d_idx, s_idx, wr_idx;

    always_comb begin
        keys = '0;
        for (int unsigned i = 0; i < TLBNUM; i++) keys[i] = tlb_q[i].key;
    end

    tlb_match u_inst_match (.entries_i(keys), .vppn_i(inst_vaddr[31:13]), .asid_i(asid),
                            .found_o(i_hit), .index_o(i_idx));
    tlb_match u_data_match (.entries_i(keys), .vppn_i(data_vaddr[31:13]), .asid_i(asid),
                            .found_o(d_hit), .index_o(d_idx));
    tlb_match u_srch_match (.entries_i(keys), .vppn_i(tlbsrch_ehi[31:13]), .asid_i(asid),
                            .found_o(s_hit), .index_o(s_idx));

    always_comb begin
        inst_res_d = translate(csr_da, inst_addr_trans_en, inst_dmw0_en, inst_dmw1_en,
                               csr_dmw0[27:25], csr_dmw1[27:25], inst_vaddr,
                               i_hit, i_idx, tlb_q[i_idx].key.ps, tlb_q[i_idx].page);
        data_res_d = translate(csr_da | cacop_op_mode_di, data_addr_trans_en,
                               data_dmw0_en, data_dmw1_en,
                               csr_dmw0[27:25], csr_dmw1[27:25], data_vaddr,
                               d_hit, d_idx, tlb_q[d_idx].key.ps, tlb_q[d_idx].page);
    end

    always_comb begin
        new_ent.key.e    = (ecode_in == 6'h3F) ? 1'b1 : ~tlbidx_in[31];
        new_ent.key.vppn = tlbehi_in[31:13];
        new_ent.key.ps   = tlbidx_in[29:24];
        new_ent.key.g    = tlbelo0_in[6] & tlbelo1_in[6];
        new_ent.key.asid = asid;
        new_ent.page[0]  = {tlbelo0_in[27:8], tlbelo0_in[3:2], tlbelo0_in[5:4],
                            tlbelo0_in[1], tlbelo0_in[0]};
        new_ent.page[1]  = {tlbelo1_in[27:8], tlbelo1_in[3:2], tlbelo1_in[5:4],
                            tlbelo1_in[1], tlbelo1_in[0]};
        wr_en            = tlbwr_en | tlbfill_en;
        wr_idx           = tlbwr_en ? tlbidx_in[IDXW-1:0] : rand_index;
    end

    // Invalidation first, then the write, so a write wins on its own entry.
    always_comb begin : p_next
        logic inv, asid_m, va_m;
        tlb_d = tlb_q;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            inv    = 1'b0;
            asid_m = (tlb_q[i].key.asid == invtlb_asid);
            va_m   = vppn_hit(tlb_q[i].key.vppn, tlb_q[i].key.ps, invtlb_vpn);
            case (invtlb_op)
                INV_ALL, INV_ALL_ALT: inv = 1'b1;
                INV_GLOBAL:           inv = tlb_q[i].key.g;
                INV_PRIVATE:          inv = ~tlb_q[i].key.g;
                INV_ASID:             inv = ~tlb_q[i].key.g & asid_m;
                INV_ASID_VA:          inv = ~tlb_q[i].key.g & asid_m & va_m;
                INV_VA:               inv = (tlb_q[i].key.g | asid_m) & va_m;
                default:              inv = 1'b0;
            endcase
            if (invtlb_en && inv) tlb_d[i].key.e = 1'b0;
        end
        if (wr_en) tlb_d[wr_idx] = new_ent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlb_q        <= '0;
            rd_q         <= '0;
            inst_res_q   <= '0;
            data_res_q   <= '0;
            srch_found_q <= 1'b0;
            srch_idx_q   <= '0;
        end else begin
            tlb_q <= tlb_d;
            rd_q  <= tlb_q[tlbidx_in[IDXW-1:0]];
            if (inst_fetch) inst_res_q <= inst_res_d;
            if (data_fetch) data_res_q <= data_res_d;
            if (tlbsrch_en) begin
                srch_found_q <= s_hit;
                srch_idx_q   <= s_idx;
            end
        end
    end

    always_comb begin
        tlbehi_out  = '0;
        tlbelo0_out = '0;
        tlbelo1_out = '0;
        tlbidx_out  = '0;
        asid_out    = '0;
        if (rd_q.key.e) begin
            tlbehi_out  = {rd_q.key.vppn, 13'b0};
            tlbelo0_out = {4'b0, rd_q.page[0].ppn, 1'b0, rd_q.key.g, rd_q.page[0].mat,
                           rd_q.page[0].plv, rd_q.page[0].d, rd_q.page[0].v};
            tlbelo1_out = {4'b0, rd_q.page[1].ppn, 1'b0, rd_q.key.g, rd_q.page[1].mat,
                           rd_q.page[1].plv, rd_q.page[1].d, rd_q.page[1].v};
            tlbidx_out  = {2'b0, rd_q.key.ps, 24'b0};
            asid_out    = rd_q.key.asid;
        end
    end

    assign {inst_tag, inst_index, inst_offset} = inst_res_q.pa;
    assign inst_tlb_found   = inst_res_q.found;
    assign inst_tlb_v       = inst_res_q.v;
    assign inst_tlb_d       = inst_res_q.d;
    assign inst_tlb_mat     = inst_res_q.mat;
    assign inst_tlb_plv     = inst_res_q.plv;
    assign {data_tag, data_index, data_offset} = data_res_q.pa;
    assign data_tlb_found   = data_res_q.found;
    assign data_tlb_index   = data_res_q.idx;
    assign data_tlb_v       = data_res_q.v;
    assign data_tlb_d       = data_res_q.d;
    assign data_tlb_mat     = data_res_q.mat;
    assign data_tlb_plv     = data_res_q.plv;
    assign search_tlb_found = srch_found_q;
    assign search_tlb_index = srch_idx_q;

    logic unused_ok;
    assign unused_ok = ^{csr_pg, csr_dmw0[31:28], csr_dmw0[24:0], csr_dmw1[31:28],
                         csr_dmw1[24:0], tlbehi_in[12:0], tlbelo0_in[31:28], tlbelo0_in[7],
                         tlbelo1_in[31:28], tlbelo1_in[7], tlbidx_in[30], tlbidx_in[23:5],
                         tlbsrch_ehi[12:0], inst_res_q.idx};

endmodule

// File: tb/tb_tlb_trans_addr.sv
// Randomised bench for tlb_trans_addr against a field-array model of the TLB.
module tb_tlb_trans_addr;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [9:0]  asid;
    logic        inst_addr_trans_en, data_addr_trans_en, inst_fetch, data_fetch;
    logic [31:0] inst_vaddr, data_vaddr;
    logic        inst_dmw0_en, inst_dmw1_en, data_dmw0_en, data_dmw1_en, cacop_op_mode_di;
    logic [7:0]  inst_index, data_index;
    logic [19:0] inst_tag, data_tag;
    logic [3:0]  inst_offset, data_offset;
    logic        inst_tlb_found, data_tlb_found;
    logic [4:0]  data_tlb_index;
    logic        inst_tlb_v, inst_tlb_d, data_tlb_v, data_tlb_d;
    logic [1:0]  inst_tlb_mat, inst_tlb_plv, data_tlb_mat, data_tlb_plv;
    logic        tlbsrch_en;
    logic [31:0] tlbsrch_ehi;
    logic        search_tlb_found;
    logic [4:0]  search_tlb_index;
    logic        tlbfill_en, tlbwr_en;
    logic [4:0]  rand_index;
    logic [31:0] tlbehi_in, tlbelo0_in, tlbelo1_in, tlbidx_in;
    logic [5:0]  ecode_in;
    logic [31:0] tlbehi_out, tlbelo0_out, tlbelo1_out, tlbidx_out;
    logic [9:0]  asid_out;
    logic        invtlb_en;
    logic [9:0]  invtlb_asid;
    logic [18:0] invtlb_vpn;
    logic [4:0]  invtlb_op;
    logic [31:0] csr_dmw0, csr_dmw1;
    logic        csr_da, csr_pg;

    tlb_trans_addr dut (
        .clk(clk), .rst_n(rst_n), .asid(asid),
        .inst_addr_trans_en(inst_addr_trans_en), .data_addr_trans_en(data_addr_trans_en),
        .inst_fetch(inst_fetch), .data_fetch(data_fetch),
        .inst_vaddr(inst_vaddr), .data_vaddr(data_vaddr),
        .inst_dmw0_en(inst_dmw0_en), .inst_dmw1_en(inst_dmw1_en),
        .data_dmw0_en(data_dmw0_en), .data_dmw1_en(data_dmw1_en),
        .cacop_op_mode_di(cacop_op_mode_di),
        .inst_index(inst_index), .inst_tag(inst_tag), .inst_offset(inst_offset),
        .data_index(data_index), .data_tag(data_tag), .data_offset(data_offset),
        .inst_tlb_found(inst_tlb_found), .data_tlb_found(data_tlb_found),
        .data_tlb_index(data_tlb_index),
        .inst_tlb_v(inst_tlb_v), .inst_tlb_d(inst_tlb_d),
        .inst_tlb_mat(inst_tlb_mat), .inst_tlb_plv(inst_tlb_plv),
        .data_tlb_v(data_tlb_v), .data_tlb_d(data_tlb_d),
        .data_tlb_mat(data_tlb_mat), .data_tlb_plv(data_tlb_plv),
        .tlbsrch_en(tlbsrch_en), .tlbsrch_ehi(tlbsrch_ehi),
        .search_tlb_found(search_tlb_found), .search_tlb_index(search_tlb_index),
        .tlbfill_en(tlbfill_en), .tlbwr_en(tlbwr_en), .rand_index(rand_index),
        .tlbehi_in(tlbehi_in), .tlbelo0_in(tlbelo0_in), .tlbelo1_in(tlbelo1_in),
        .tlbidx_in(tlbidx_in), .ecode_in(ecode_in),
        .tlbehi_out(tlbehi_out), .tlbelo0_out(tlbelo0_out), .tlbelo1_out(tlbelo1_out),
        .tlbidx_out(tlbidx_out), .asid_out(asid_out),
        .invtlb_en(invtlb_en), .invtlb_asid(invtlb_asid), .invtlb_vpn(invtlb_vpn),
        .invtlb_op(invtlb_op), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
        .csr_da(csr_da), .csr_pg(csr_pg)
    );

    always #5 clk = ~clk;

    // Model state: one slot per entry, fields kept as plain arrays.
    logic        m_e    [32];
    logic [18:0] m_vppn [32];
    logic [5:0]  m_ps   [32];
    logic        m_g    [32];
    logic [9:0]  m_asid [32];
    logic [19:0] m_ppn  [32][2];
    logic [1:0]  m_plv  [32][2];
    logic [1:0]  m_mat  [32][2];
    logic        m_d    [32][2];
    logic        m_v    [32][2];

    // Expected registered outputs: {pa, found, v, d, mat, plv}.
    logic [38:0] e_inst, e_data;
    logic [4:0]  e_didx, e_sidx;
    logic        e_sfound;
    logic [31:0] e_ehi, e_elo0, e_elo1, e_idx;
    logic [9:0]  e_asid;

    int n_pass = 0, n_tot = 0;
    logic cmp_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic model_lookup(input logic [18:0] vppn, input logic [9:0] as,
                                output logic found, output logic [4:0] idx);
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 32; i++) begin
            if (m_e[i] && (m_g[i] || m_asid[i] == as) &&
                ((m_ps[i] == 6'd21) ? (vppn[18:9] == m_vppn[i][18:9]) : (vppn == m_vppn[i]))) begin
                found = 1'b1;
                idx   = 5'(i);
            end
        end
    endtask

    task automatic model_translate(input logic direct, input logic te, input logic dm0,
                                   input logic dm1, input logic [31:0] va,
                                   output logic [38:0] res, output logic [4:0] ridx);
        logic [31:0] pa;
        logic        f, v, d, odd;
        logic [1:0]  mat, plv;
        logic [4:0]  k;
        pa = va; f = 0; v = 0; d = 0; mat = 2'd1; plv = 0; ridx = 0;
        if (!direct && te) begin
            model_lookup(va[31:13], asid, f, k);
            mat = 2'd0;
            if (f) begin
                odd  = (m_ps[k] == 6'd21) ? va[21] : va[12];
                v    = m_v[k][odd];
                d    = m_d[k][odd];
                mat  = m_mat[k][odd];
                plv  = m_plv[k][odd];
                ridx = k;
                if (m_ps[k] == 6'd21) pa = (32'(m_ppn[k][odd] >> 9) << 21) | (va & 32'h001F_FFFF);
                else                  pa = (32'(m_ppn[k][odd]) << 12) | (va & 32'h0000_0FFF);
            end
        end else if (!direct && dm0) begin
            pa = (32'(csr_dmw0[27:25]) << 29) | (va & 32'h1FFF_FFFF);
        end else if (!direct && dm1) begin
            pa = (32'(csr_dmw1[27:25]) << 29) | (va & 32'h1FFF_FFFF);
        end
        res = {pa, f, v, d, mat, plv};
    endtask

    task automatic model_update();
        logic [38:0] r;
        logic [4:0]  k, t;
        logic        inv, am, vm;
        if (inst_fetch) model_translate(csr_da, inst_addr_trans_en, inst_dmw0_en, inst_dmw1_en,
                                        inst_vaddr, e_inst, k);
        if (data_fetch) begin
            model_translate(csr_da | cacop_op_mode_di, data_addr_trans_en, data_dmw0_en,
                            data_dmw1_en, data_vaddr, r, k);
            e_data = r;
            e_didx = k;
        end
        if (tlbsrch_en) model_lookup(tlbsrch_ehi[31:13], asid, e_sfound, e_sidx);
        k = tlbidx_in[4:0];
        if (m_e[k]) begin
            e_ehi  = {m_vppn[k], 13'b0};
            e_elo0 = {4'b0, m_ppn[k][0], 1'b0, m_g[k], m_mat[k][0], m_plv[k][0], m_d[k][0], m_v[k][0]};
            e_elo1 = {4'b0, m_ppn[k][1], 1'b0, m_g[k], m_mat[k][1], m_plv[k][1], m_d[k][1], m_v[k][1]};
            e_idx  = {2'b0, m_ps[k], 24'b0};
            e_asid = m_asid[k];
        end else begin
            e_ehi = 0; e_elo0 = 0; e_elo1 = 0; e_idx = 0; e_asid = 0;
        end
        if (invtlb_en) begin
            for (int i = 0; i < 32; i++) begin
                am = (m_asid[i] == invtlb_asid);
                vm = (m_ps[i] == 6'd21) ? (m_vppn[i][18:9] == invtlb_vpn[18:9])
                                        : (m_vppn[i] == invtlb_vpn);
                case (invtlb_op)
                    5'd0, 5'd1: inv = 1;
                    5'd2:       inv = m_g[i];
                    5'd3:       inv = !m_g[i];
                    5'd4:       inv = !m_g[i] && am;
                    5'd5:       inv = !m_g[i] && am && vm;
                    5'd6:       inv = (m_g[i] || am) && vm;
                    default:    inv = 0;
                endcase
                if (inv) m_e[i] = 1'b0;
            end
        end
        if (tlbwr_en || tlbfill_en) begin
            t = tlbwr_en ? tlbidx_in[4:0] : rand_index;
            m_e[t]       = (ecode_in == 6'h3F) ? 1'b1 : !tlbidx_in[31];
            m_vppn[t]    = tlbehi_in[31:13];
            m_ps[t]      = tlbidx_in[29:24];
            m_g[t]       = tlbelo0_in[6] && tlbelo1_in[6];
            m_asid[t]    = asid;
            m_ppn[t][0]  = tlbelo0_in[27:8]; m_ppn[t][1] = tlbelo1_in[27:8];
            m_plv[t][0]  = tlbelo0_in[3:2];  m_plv[t][1] = tlbelo1_in[3:2];
            m_mat[t][0]  = tlbelo0_in[5:4];  m_mat[t][1] = tlbelo1_in[5:4];
            m_d[t][0]    = tlbelo0_in[1];    m_d[t][1]   = tlbelo1_in[1];
            m_v[t][0]    = tlbelo0_in[0];    m_v[t][1]   = tlbelo1_in[0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("inst", {25'b0, inst_tag, inst_index, inst_offset, inst_tlb_found, inst_tlb_v,
                         inst_tlb_d, inst_tlb_mat, inst_tlb_plv}, {25'b0, e_inst});
            chk("data", {20'b0, data_tag, data_index, data_offset, data_tlb_found, data_tlb_v,
                         data_tlb_d, data_tlb_mat, data_tlb_plv, data_tlb_index},
                {20'b0, e_data, e_didx});
            chk("srch", {58'b0, search_tlb_found, search_tlb_index}, {58'b0, e_sfound, e_sidx});
            chk("rd_ehi",  {32'b0, tlbehi_out},  {32'b0, e_ehi});
            chk("rd_elo0", {32'b0, tlbelo0_out}, {32'b0, e_elo0});
            chk("rd_elo1", {32'b0, tlbelo1_out}, {32'b0, e_elo1});
            chk("rd_idx",  {32'b0, tlbidx_out},  {32'b0, e_idx});
            chk("rd_asid", {54'b0, asid_out},    {54'b0, e_asid});
        end
    end

    function automatic logic [18:0] rand_vppn(input logic [4:0] slot);
        return {5'h03, slot, 1'($urandom_range(0, 1)), 6'b0, 2'($urandom_range(0, 3))};
    endfunction

    function automatic logic [31:0] rand_va();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return {rand_vppn(5'($urandom_range(0, 31))), 13'($urandom)};
    endfunction

    task automatic rand_inputs();
        logic [4:0] widx, t;
        logic [5:0] ps;
        asid               = 10'($urandom_range(0, 2));
        inst_fetch         = ($urandom_range(0, 4) != 0);
        data_fetch         = ($urandom_range(0, 4) != 0);
        inst_addr_trans_en = ($urandom_range(0, 9) < 7);
        data_addr_trans_en = ($urandom_range(0, 9) < 7);
        inst_dmw0_en       = ($urandom_range(0, 4) == 0);
        inst_dmw1_en       = ($urandom_range(0, 4) == 0);
        data_dmw0_en       = ($urandom_range(0, 4) == 0);
        data_dmw1_en       = ($urandom_range(0, 4) == 0);
        cacop_op_mode_di   = ($urandom_range(0, 9) == 0);
        csr_da             = ($urandom_range(0, 9) == 0);
        csr_pg             = 1'($urandom);
        csr_dmw0           = $urandom;
        csr_dmw1           = $urandom;
        inst_vaddr         = rand_va();
        data_vaddr         = rand_va();
        tlbsrch_en         = ($urandom_range(0, 2) == 0);
        tlbsrch_ehi        = rand_va();
        tlbwr_en           = ($urandom_range(0, 5) == 0);
        tlbfill_en         = ($urandom_range(0, 5) == 0);
        widx               = 5'($urandom_range(0, 31));
        rand_index         = 5'($urandom_range(0, 31));
        t                  = tlbwr_en ? widx : rand_index;
        ps                 = ($urandom_range(0, 1) == 0) ? 6'd12 : 6'd21;
        tlbidx_in          = {1'($urandom_range(0, 3) == 0), 1'($urandom), ps, 19'($urandom), widx};
        tlbehi_in          = {rand_vppn(t), 13'($urandom)};
        tlbelo0_in         = $urandom;
        tlbelo1_in         = $urandom;
        ecode_in           = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
        invtlb_en          = ($urandom_range(0, 11) == 0);
        invtlb_op          = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 1))
                                                         : 5'($urandom_range(2, 9));
        invtlb_asid        = 10'($urandom_range(0, 2));
        invtlb_vpn         = rand_vppn(5'($urandom_range(0, 31)));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_e[i] = 0; m_vppn[i] = 0; m_ps[i] = 0; m_g[i] = 0; m_asid[i] = 0;
            for (int j = 0; j < 2; j++) begin
                m_ppn[i][j] = 0; m_plv[i][j] = 0; m_mat[i][j] = 0; m_d[i][j] = 0; m_v[i][j] = 0;
            end
        end
        e_inst = 0; e_data = 0; e_didx = 0; e_sidx = 0; e_sfound = 0;
        e_ehi = 0; e_elo0 = 0; e_elo1 = 0; e_idx = 0; e_asid = 0;
        asid = 0; inst_addr_trans_en = 0; data_addr_trans_en = 0; inst_fetch = 0; data_fetch = 0;
        inst_vaddr = 0; data_vaddr = 0; inst_dmw0_en = 0; inst_dmw1_en = 0; data_dmw0_en = 0;
        data_dmw1_en = 0; cacop_op_mode_di = 0; tlbsrch_en = 0; tlbsrch_ehi = 0; tlbfill_en = 0;
        tlbwr_en = 0; rand_index = 0; tlbehi_in = 0; tlbelo0_in = 0; tlbelo1_in = 0;
        tlbidx_in = 0; ecode_in = 0; invtlb_en = 0; invtlb_asid = 0; invtlb_vpn = 0;
        invtlb_op = 0; csr_dmw0 = 0; csr_dmw1 = 0; csr_da = 0; csr_pg = 0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_on = 1'b1;

        tlbidx_in = 32'h0; step();
        chk("reset_rd_ehi", {32'b0, tlbehi_out}, 64'h0);
        chk("reset_rd_elo0", {32'b0, tlbelo0_out}, 64'h0);
        chk("reset_rd_idx", {32'b0, tlbidx_out}, 64'h0);
        chk("reset_found", {61'b0, inst_tlb_found, data_tlb_found, search_tlb_found}, 64'h0);

        tlbidx_in = 32'h0C00_0003; tlbehi_in = 32'h0000_6000;
        tlbelo0_in = 32'h0000_0611; tlbelo1_in = 32'h0000_0711; asid = 0; ecode_in = 0;
        tlbwr_en = 1; step(); tlbwr_en = 0;
        data_fetch = 1; data_vaddr = 32'h0000_6ABC; data_addr_trans_en = 1; step();
        chk("wr_rd_ehi", {32'b0, tlbehi_out}, 64'h0000_6000);
        chk("wr_rd_elo0", {32'b0, tlbelo0_out}, 64'h0000_0611);
        chk("wr_rd_elo1", {32'b0, tlbelo1_out}, 64'h0000_0711);
        chk("wr_rd_idx", {32'b0, tlbidx_out}, 64'h0C00_0000);
        chk("hit_tag", {44'b0, data_tag}, 64'h6);
        chk("hit_index", {56'b0, data_index}, 64'hAB);
        chk("hit_offset", {60'b0, data_offset}, 64'hC);
        chk("hit_found_idx", {58'b0, data_tlb_found, data_tlb_index}, {58'b0, 1'b1, 5'd3});
        chk("hit_v_mat", {61'b0, data_tlb_v, data_tlb_mat}, {61'b0, 1'b1, 2'b01});
        chk("model_hit_pa", {32'b0, e_data[38:7]}, 64'h0000_6ABC);

        data_fetch = 0; tlbsrch_en = 1; tlbsrch_ehi = 32'h0000_6000; step();
        chk("srch_hit", {58'b0, search_tlb_found, search_tlb_index}, {58'b0, 1'b1, 5'd3});
        asid = 10'd5; step();
        chk("srch_asid_miss", {63'b0, search_tlb_found}, 64'h0);
        tlbsrch_en = 0; asid = 0;

        invtlb_en = 1; invtlb_op = 5'd0; step(); invtlb_en = 0;
        data_fetch = 1; step();
        chk("inv_miss_found", {63'b0, data_tlb_found}, 64'h0);
        chk("inv_miss_tag", {44'b0, data_tag}, 64'h6);
        chk("inv_rd_ehi", {32'b0, tlbehi_out}, 64'h0);
        chk("inv_rd_elo0", {32'b0, tlbelo0_out}, 64'h0);
        chk("inv_rd_idx", {32'b0, tlbidx_out}, 64'h0);

        data_fetch = 0; inst_fetch = 1; inst_addr_trans_en = 0; inst_dmw0_en = 1;
        csr_dmw0 = 0; inst_vaddr = 32'h9000_1234; step();
        chk("dmw_tag", {44'b0, inst_tag}, 64'h10001);
        chk("dmw_index", {56'b0, inst_index}, 64'h23);
        chk("dmw_offset", {60'b0, inst_offset}, 64'h4);
        chk("dmw_found_mat", {61'b0, inst_tlb_found, inst_tlb_mat}, {61'b0, 1'b0, 2'b01});
        chk("model_dmw_pa", {32'b0, e_inst[38:7]}, 64'h1000_1234);

        for (int n = 0; n < 2000; n++) begin
            rand_inputs();
            step();
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
